uart_rx_engine: RTL and testbench
=================================

// Module: uart_rx_engine
// PURPOSE
//  Serial receive path of the J1 UART peripheral: 8N1 deserialiser with 16x oversampling,
//  start-bit validation, framing/overrun detection and a show-ahead byte FIFO. It sits between
//  the uart_rx pin and the peripheral register decode, which pops bytes via rd_en.
// PARAMETERS
//  CLK_FREQ    50000000  system clock in Hz
//  BAUD        115200    line rate in bit/s
//  FIFO_DEPTH  8         receive FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  uart_rx    in   1  asynchronous serial input, idle high
//  rd_en      in   1  pop head byte; ignored when rx_valid=0
//  err_clr    in   1  clear sticky frame_err/overrun/parity_err
//  rx_data    out  8  FIFO head byte, valid while rx_valid=1
//  rx_valid   out  1  FIFO not empty
//  rx_busy    out  1  frame in progress (state != IDLE)
//  frame_err  out  1  sticky: stop bit sampled low
//  overrun    out  1  sticky: byte completed while FIFO full
//  parity_err out  1  sticky: parity mismatch (tied 0 without UART_PARITY_EN)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, FIFO empty, 2-FF synchroniser and edge register preset 1.
//    rst mid-frame aborts the frame; no partial byte is pushed.
//  - Tick: OS_DIV = round(CLK_FREQ/(16*BAUD)) (27 at defaults); 1-cycle os_tick every OS_DIV clks.
//    Tick counter and 4-bit sample counter restart on start-edge detect so sampling is frame-aligned.
//  - Bit value = majority of synchronised samples 7,8,9 within the bit; decided at sample 9.
//  - FSM: IDLE -> START on falling edge of synchronised rx.
//    START: bit=1 -> IDLE (glitch rejected, no flags); bit=0 -> DATA.
//    DATA: 8 bits, LSB first, shift right; after bit 7 -> PARITY (macro) else STOP.
//    STOP: bit=1 -> push byte, IDLE (back-to-back frames accepted immediately);
//          bit=0 -> frame_err=1, byte discarded, BREAK.
//    BREAK: wait until synchronised rx=1, then IDLE.
//  - Latency: byte visible on rx_valid/rx_data 1 clk after the stop-bit decision cycle.
//  - FIFO: show-ahead; pop on rd_en&&rx_valid. Push when full: byte dropped, overrun=1, unless
//    rd_en pops in the same cycle, then push accepted. Push+pop when empty: push only.
//    Pointers wrap modulo FIFO_DEPTH; one extra pointer bit distinguishes full from empty.
//  - Sticky flags: set has priority over err_clr in the same cycle.
// CONFIGURATION
//  UART_PARITY_EN defined: 8E1 frame; PARITY state samples one bit after data; mismatch vs even
//    parity sets parity_err, byte still pushed; then STOP.
//  Undefined: 8N1 only, no PARITY state, parity_err constant 0.
// STRUCTURE
//  uart_defs.vh (shared with TX side): FSM state encodings, OS_RATE=16, SAMPLE_LO/MID/HI=7/8/9,
//    OS_DIV computation macro.
//  Sub-module uart_rx_fifo (DEPTH param, wr_en/din/rd_en/dout/empty/full), instantiated once.
// TESTING  (bit period = 16*OS_DIV = 432 clks at defaults)
//  1. Frames 0x48,0x45,0x4C,0x50 back-to-back, no pops -> rx_valid=1, pops return H,E,L,P in order,
//     no flags.
//  2. 3-clk low pulse on idle uart_rx -> FSM returns IDLE, rx_valid stays 0, no flags.
//  3. Frame 0x55 with stop bit driven low, then line high -> frame_err=1, FIFO empty; next 0x41
//     received; err_clr -> frame_err=0.
//  4. FIFO_DEPTH+1 = 9 frames without pops -> first 8 bytes stored, 9th dropped, overrun=1;
//     repeat with rd_en coinciding with 9th push -> accepted, overrun=0.
//  5. rst asserted at data bit 4 of 0x7E, then frame 0x31 -> only 0x31 in FIFO, all flags 0.
//  6. UART_PARITY_EN: 0x48 with parity bit 1 (wrong) -> parity_err=1, 0x48 pushed; correct
//     parity 0 -> no flag.

Source files
------------

// File: rtl/uart_rx_engine_pkg.sv
// Shared definitions for the UART receive path: FSM states, oversampling constants
// and the oversampling divider calculation.
package uart_rx_engine_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

    localparam int unsigned OsRate    = 16;
    localparam logic [3:0]  SampleLo  = 4'd7;
    localparam logic [3:0]  SampleMid = 4'd8;
    localparam logic [3:0]  SampleHi  = 4'd9;

    // Rounded CLK_FREQ / (OsRate * BAUD), never below 1.
    function automatic int unsigned calc_os_div(input int unsigned clk_freq,
                                                input int unsigned baud);
        int unsigned div;
        div = (clk_freq + (OsRate * baud) / 2) / (OsRate * baud);
        return (div == 0) ? 1 : div;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_engine_fifo.sv
// Show-ahead byte FIFO for received UART data. Pops are ignored when empty; a push while
// full is accepted only if a pop happens in the same cycle.
module uart_rx_engine_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] din,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int unsigned Aw = $clog2(DEPTH);

    logic [Aw:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]  mem_q [DEPTH];
    logic        do_rd, do_wr;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign dout  = mem_q[rd_ptr_q[Aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[Aw-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: 16x oversampled deserialiser with framing/overrun detection and a
// show-ahead FIFO. Define UART_PARITY_EN for 8E1 frames with parity checking (8N1 otherwise).
module uart_rx_engine
    import uart_rx_engine_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int unsigned OsDiv = calc_os_div(CLK_FREQ, BAUD);
    localparam int unsigned DivW  = (OsDiv > 1) ? $clog2(OsDiv) : 1;

    rx_state_e   state_q;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [DivW-1:0] div_cnt_q;
    logic [3:0]  smp_cnt_q;
    logic        smp_lo_q, smp_mid_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic        frame_err_q, overrun_q;

    logic        start_edge, os_tick, bit_done, bit_val;
    logic        push, frame_set, overrun_set;
    logic [7:0]  fifo_dout;
    logic        fifo_empty, fifo_full;

    assign start_edge = (state_q == StIdle) && rx_prev_q && !rx_sync_q;
    assign os_tick    = (div_cnt_q == DivW'(OsDiv - 1));
    assign bit_done   = os_tick && (smp_cnt_q == SampleHi);
    assign bit_val    = majority3(smp_lo_q, smp_mid_q, rx_sync_q);

    assign push        = (state_q == StStop) && bit_done && bit_val;
    assign frame_set   = (state_q == StStop) && bit_done && !bit_val;
    assign overrun_set = push && fifo_full && !(rd_en && rx_valid);

    // Synchroniser, edge register and frame-aligned oversampling timebase.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            div_cnt_q <= '0;
            smp_cnt_q <= '0;
            smp_lo_q  <= 1'b1;
            smp_mid_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            if (start_edge) begin
                div_cnt_q <= '0;
                smp_cnt_q <= '0;
            end else if (os_tick) begin
                div_cnt_q <= '0;
                smp_cnt_q <= smp_cnt_q + 1'b1;
            end else begin
                div_cnt_q <= div_cnt_q + 1'b1;
            end
            if (os_tick && smp_cnt_q == SampleLo)  smp_lo_q  <= rx_sync_q;
            if (os_tick && smp_cnt_q == SampleMid) smp_mid_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_edge) state_q <= StStart;
                end
                StStart: begin
                    bit_cnt_q <= '0;
                    if (bit_done) state_q <= bit_val ? StIdle : StData;
                end
                StData: begin
                    if (bit_done) begin
                        shift_q   <= {bit_val, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
`ifdef UART_PARITY_EN
                StParity: begin
                    if (bit_done) state_q <= StStop;
                end
`endif
                StStop: begin
                    if (bit_done) state_q <= bit_val ? StIdle : StBreak;
                end
                StBreak: begin
                    if (rx_sync_q) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (frame_set)    frame_err_q <= 1'b1;
            else if (err_clr) frame_err_q <= 1'b0;
            if (overrun_set)  overrun_q   <= 1'b1;
            else if (err_clr) overrun_q   <= 1'b0;
        end
    end

`ifdef UART_PARITY_EN
    logic parity_err_q;
    logic parity_set;

    // Even parity: the parity bit must equal the XOR of the data bits.
    assign parity_set = (state_q == StParity) && bit_done && (bit_val != ^shift_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if (parity_set) begin
            parity_err_q <= 1'b1;
        end else if (err_clr) begin
            parity_err_q <= 1'b0;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    uart_rx_engine_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (push),
        .din   (shift_q),
        .rd_en (rd_en),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rx_valid  = !fifo_empty;
    assign rx_data   = rx_valid ? fifo_dout : 8'h00;
    assign rx_busy   = (state_q != StIdle);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed scoreboard bench for uart_rx_engine at a reduced clock/baud ratio (4 clks per
// oversample tick, 64 clks per bit).
module tb_uart_rx_engine;

    localparam int unsigned ClkFreq = 6400000;
    localparam int unsigned Baud    = 100000;
    localparam int unsigned OsDiv   = ClkFreq / (16 * Baud);
    localparam int unsigned BitClks = 16 * OsDiv;
    localparam int unsigned Depth   = 8;

    logic       clk = 1'b0;
    logic       rst, uart_rx, rd_en, err_clr;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, overrun, parity_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int push_clk = 0;

    always #5 clk = ~clk;

    uart_rx_engine #(
        .CLK_FREQ   (ClkFreq),
        .BAUD       (Baud),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        uart_rx = 1'b0;
        clks(BitClks);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            clks(BitClks);
        end
`ifdef UART_PARITY_EN
        uart_rx = par_b;
        clks(BitClks);
`else
        if (par_b === 1'bx) uart_rx = 1'b1;
`endif
        uart_rx = stop_b;
        clks(BitClks);
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b1, ^d);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        int t;
        t = 0;
        while (!rx_valid && t < 4 * BitClks) begin
            clks(1);
            t++;
        end
        check({tag, "_valid"}, 32'(rx_valid), 32'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(rx_data), 32'(e));
        end
        rd_en = 1'b1;
        clks(1);
        rd_en = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic fe, input logic ov,
                               input logic pe);
        check({tag, "_frame_err"}, 32'(frame_err), 32'(fe));
        check({tag, "_overrun"}, 32'(overrun), 32'(ov));
        check({tag, "_parity_err"}, 32'(parity_err), 32'(pe));
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        clks(1);
        err_clr = 1'b0;
    endtask

    // Counts clocks from frame start until rx_busy drops (the stop-bit decision edge).
    task automatic measure_busy_fall(output int n);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        n    = 0;
        while (cnt < 20 * BitClks) begin
            clks(1);
            cnt++;
            if (rx_busy) seen = 1'b1;
            else if (seen) begin
                n = cnt;
                break;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        uart_rx = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        clks(4);
        rst = 1'b0;
        clks(2);
        check("reset_valid", 32'(rx_valid), 32'(0));
        check("reset_busy", 32'(rx_busy), 32'(0));
        check("reset_data", 32'(rx_data), 32'(0));
        check_flags("reset", 1'b0, 1'b0, 1'b0);

        // Back-to-back frames, then drain in order.
        send_good(8'h48);
        send_good(8'h45);
        send_good(8'h4C);
        send_good(8'h50);
        uart_rx = 1'b1;
        clks(4);
        check("b2b_valid", 32'(rx_valid), 32'(1));
        check_flags("b2b", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pop_check("b2b_pop");
        check("b2b_empty", 32'(rx_valid), 32'(0));

        // Short glitch on an idle line.
        uart_rx = 1'b0;
        clks(3);
        uart_rx = 1'b1;
        clks(2 * BitClks);
        check("glitch_busy", 32'(rx_busy), 32'(0));
        check("glitch_valid", 32'(rx_valid), 32'(0));
        check_flags("glitch", 1'b0, 1'b0, 1'b0);

        // Framing error, recovery, sticky clear.
        send_frame(8'h55, 1'b0, ^8'h55);
        check("ferr_set", 32'(frame_err), 32'(1));
        uart_rx = 1'b1;
        clks(BitClks);
        check("ferr_busy", 32'(rx_busy), 32'(0));
        check("ferr_empty", 32'(rx_valid), 32'(0));
        send_good(8'h41);
        uart_rx = 1'b1;
        pop_check("ferr_next");
        check("ferr_sticky", 32'(frame_err), 32'(1));
        pulse_err_clr();
        check("ferr_clr", 32'(frame_err), 32'(0));

        // Overrun: ninth frame into a full FIFO is dropped.
        for (int i = 0; i < 8; i++) send_good(8'hA0 + 8'(i));
        fork
            send_frame(8'hA8, 1'b1, ^8'hA8);
            measure_busy_fall(push_clk);
        join
        uart_rx = 1'b1;
        clks(2);
        check("ovr_set", 32'(overrun), 32'(1));
        check("ovr_latency",
              32'((push_clk >= int'(9 * BitClks + 7 * OsDiv)) &&
                  (push_clk <= int'(9 * BitClks + 11 * OsDiv + 4))), 32'(1));
        for (int i = 0; i < 8; i++) pop_check("ovr_pop");
        check("ovr_empty", 32'(rx_valid), 32'(0));
        pulse_err_clr();
        check("ovr_clr", 32'(overrun), 32'(0));

        // Push into a full FIFO with a coinciding pop is accepted.
        for (int i = 0; i < 8; i++) send_good(8'hB0 + 8'(i));
        exp_q.push_back(8'hB8);
        fork
            send_frame(8'hB8, 1'b1, ^8'hB8);
            begin
                clks(push_clk - 1);
                rd_en = 1'b1;
                check("pp_head", 32'(rx_data), 32'(exp_q.pop_front()));
                clks(1);
                rd_en = 1'b0;
            end
        join
        uart_rx = 1'b1;
        clks(2);
        check("pp_no_overrun", 32'(overrun), 32'(0));
        for (int i = 0; i < 8; i++) pop_check("pp_pop");
        check("pp_empty", 32'(rx_valid), 32'(0));

        // Reset mid-frame aborts it.
        uart_rx = 1'b0;
        clks(BitClks);
        for (int i = 0; i < 4; i++) begin
            uart_rx = (8'h7E >> i) & 8'h01;
            clks(BitClks);
        end
        uart_rx = 1'b1;
        clks(BitClks / 2);
        check("rst_mid_busy", 32'(rx_busy), 32'(1));
        rst = 1'b1;
        clks(2);
        rst = 1'b0;
        clks(1);
        check("rst_busy", 32'(rx_busy), 32'(0));
        check("rst_valid", 32'(rx_valid), 32'(0));
        clks(BitClks);
        send_good(8'h31);
        uart_rx = 1'b1;
        clks(2);
        check_flags("rst_after", 1'b0, 1'b0, 1'b0);
        pop_check("rst_pop");
        check("rst_empty", 32'(rx_valid), 32'(0));

`ifdef UART_PARITY_EN
        // Wrong parity flags but still delivers the byte; correct parity does not flag.
        exp_q.push_back(8'h48);
        send_frame(8'h48, 1'b1, 1'b1);
        uart_rx = 1'b1;
        clks(2);
        check("par_bad_flag", 32'(parity_err), 32'(1));
        pop_check("par_bad_pop");
        pulse_err_clr();
        check("par_clr", 32'(parity_err), 32'(0));
        send_good(8'h48);
        uart_rx = 1'b1;
        clks(2);
        check("par_good_flag", 32'(parity_err), 32'(0));
        pop_check("par_good_pop");
`endif

        check("final_queue_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
